// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache.
package icache_pkg;

   // Controller task source tag that marks a completion belonging to the icache port
   localparam logic [1:0] TASK_SRC_ICACHE = 2'b10;
   // Controller access type for a full 32-bit word
   localparam logic [2:0] MEM_TYPE_W      = 3'b000;

   // DRAIN: miss outstanding but the fetch was flushed, so the returned word is only filled
   typedef enum logic [1:0] {IDLE, LOOKUP, MISS, DRAIN} icache_state_e;

endpackage

// File: rtl/icache_storage.sv
// Direct-mapped line storage: valid/tag/data arrays, combinational read, one write port.
module icache_storage #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned TAG_BITS   = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_data,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data
);

   localparam int unsigned LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   // Valid bits are the only state that reset must clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data arrays need no reset; they are qualified by the valid bit
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Optional feature: define ICACHE_PERF_CNT_EN to add hit/miss/stall counters.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ready,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   input  logic        flush_in,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_data_out,
   output logic        mem_r_nw_out,
   output logic [2:0]  mem_type_out,
   output logic        mem_activate,
   input  logic [31:0] mem_data_in,
   input  logic        mem_data_avail,
   input  logic [1:0]  mem_task_src,
   input  logic        mem_icache_block
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

   icache_state_e state_q, state_d;
   logic [31:2]   addr_q, addr_d;
   logic          inst_valid_q, inst_valid_d;
   logic [31:0]   inst_out_q, inst_out_d;
   logic          mem_activate_q, mem_activate_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic          stale_q, stale_d;
   logic          fill_we;

   logic                rd_valid;
   logic [TAG_BITS-1:0] rd_tag;
   logic [31:0]         rd_data;
   logic                hit;
   logic                mem_return;

   icache_storage #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_storage (
      .clk      (clk_in),
      .rst      (rst_in),
      .rd_index (addr_q[INDEX_BITS+1:2]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .we       (fill_we && rdy_in),
      .wr_index (addr_q[INDEX_BITS+1:2]),
      .wr_tag   (addr_q[31:INDEX_BITS+2]),
      .wr_data  (mem_data_in)
   );

   assign hit        = rd_valid && (rd_tag == addr_q[31:INDEX_BITS+2]);
   assign mem_return = mem_data_avail && (mem_task_src == TASK_SRC_ICACHE);

   // Next-state and registered-output decisions; flush always beats a completing fetch
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      inst_valid_d   = 1'b0;
      inst_out_d     = inst_out_q;
      mem_activate_d = mem_activate_q;
      mem_addr_d     = mem_addr_q;
      stale_d        = stale_q;
      fill_we        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!flush_in && fetch_valid) begin
               addr_d  = fetch_addr[31:2];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (flush_in) begin
               state_d = IDLE;
            end else if (hit) begin
               inst_valid_d = 1'b1;
               inst_out_d   = rd_data;
               state_d      = IDLE;
            end else begin
               mem_activate_d = 1'b1;
               mem_addr_d     = {addr_q, 2'b00};
               state_d        = MISS;
            end
         end
         MISS, DRAIN: begin
            if (mem_return) begin
               fill_we        = 1'b1;
               mem_activate_d = 1'b0;
               stale_d        = 1'b0;
               state_d        = IDLE;
               if (state_q == MISS && !flush_in) begin
                  inst_valid_d = 1'b1;
                  inst_out_d   = mem_data_in;
               end
            end else if (flush_in) begin
               // Request cannot be withdrawn from the controller; wait it out
               stale_d = 1'b1;
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; rdy_in low freezes everything
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         inst_valid_q   <= 1'b0;
         inst_out_q     <= '0;
         mem_activate_q <= 1'b0;
         mem_addr_q     <= '0;
         stale_q        <= 1'b0;
      end else if (rdy_in) begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         inst_valid_q   <= inst_valid_d;
         inst_out_q     <= inst_out_d;
         mem_activate_q <= mem_activate_d;
         mem_addr_q     <= mem_addr_d;
         stale_q        <= stale_d;
      end
   end

   assign fetch_ready  = (state_q == IDLE);
   assign inst_valid   = inst_valid_q;
   assign inst_out     = inst_out_q;
   assign mem_activate = mem_activate_q;
   assign mem_addr_out = mem_addr_q;
   assign mem_data_out = '0;
   assign mem_r_nw_out = 1'b1;
   assign mem_type_out = MEM_TYPE_W;

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q, stall_cnt_q;
   logic        lookup_hit, lookup_miss, miss_stall;
   logic        unused_bits;

   assign lookup_hit  = (state_q == LOOKUP) && !flush_in && hit;
   assign lookup_miss = (state_q == LOOKUP) && !flush_in && !hit;
   assign miss_stall  = (state_q == MISS || state_q == DRAIN) && mem_icache_block;
   assign unused_bits = ^{fetch_addr[1:0], stale_q};

   // Saturating event counters
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else if (rdy_in) begin
         if (lookup_hit && hit_cnt_q != '1)   hit_cnt_q   <= hit_cnt_q + 32'd1;
         if (lookup_miss && miss_cnt_q != '1) miss_cnt_q  <= miss_cnt_q + 32'd1;
         if (miss_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   logic unused_bits;
   // stale_q mirrors DRAIN; kept as an explicit flag for debug visibility
   assign unused_bits = ^{fetch_addr[1:0], mem_icache_block, stale_q};
`endif

endmodule
